fault_campaign_ctrl: RTL

FAULT_CAMPAIGN_CTRL -- requirements
Module: fault_campaign_ctrl

---
 rtl/fault_campaign_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/fault_campaign_ctrl.sv
// Fault-injection campaign sequencer: one golden pass, then one injected pass per fault ID.
// Optional macro FI_EARLY_ABORT_EN ends an injected pass at its first detected mismatch.
module fault_campaign_ctrl #(
    parameter int                 FID_W  = 17,
    parameter int                 OUT_W  = 32,
    parameter int                 STIM_W = 32,
    parameter int                 CYCLES = 2,
    parameter logic [STIM_W-1:0]  SEED   = STIM_W'(32'h8000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [FID_W-1:0]  batch_start,
    input  logic [FID_W-1:0]  batch_end,
    output logic [STIM_W-1:0] stim_out,
    output logic [FID_W-1:0]  fault_id,
    input  logic [OUT_W-1:0]  dut_resp,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [FID_W-1:0]  res_fid,
    output logic              res_detected,
    output logic [3:0]        res_cycle,
    output logic              busy,
    output logic              done,
    output logic [FID_W-1:0]  det_cnt,
    output logic [FID_W-1:0]  tot_cnt
);

    localparam logic [FID_W-1:0]  NO_FAULT  = '1;
    localparam logic [FID_W-1:0]  FID_ONE   = FID_W'(1);
    localparam logic [4:0]        LAST_K    = 5'(CYCLES - 1);
    // Galois taps for x^32 + x^22 + x^2 + x + 1, truncated for narrower stimulus
    localparam logic [STIM_W-1:0] LFSR_TAPS = STIM_W'(64'h0000_0000_0040_0007);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GOLDEN = 3'd1,
        INJECT = 3'd2,
        REPORT = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [STIM_W-1:0]  lfsr_q, lfsr_d;
    logic [4:0]         k_q, k_d;
    logic [FID_W-1:0]   cur_fid_q, cur_fid_d;
    logic [FID_W-1:0]   end_fid_q, end_fid_d;
    logic [FID_W-1:0]   res_fid_q, res_fid_d;
    logic               res_det_q, res_det_d;
    logic [3:0]         res_cyc_q, res_cyc_d;
    logic [FID_W-1:0]   det_cnt_q, det_cnt_d;
    logic [FID_W-1:0]   tot_cnt_q, tot_cnt_d;
    logic [OUT_W-1:0]   golden_q [CYCLES];

    logic [STIM_W-1:0]  lfsr_step;
    logic [OUT_W-1:0]   golden_sel;
    logic               mismatch;
    logic               first_miss;
    logic               last_k;
    logic [FID_W-1:0]   next_fid;

    assign lfsr_step  = {lfsr_q[STIM_W-2:0], 1'b0} ^ ({STIM_W{lfsr_q[STIM_W-1]}} & LFSR_TAPS);
    assign last_k     = (k_q == LAST_K);
    assign next_fid   = cur_fid_q + FID_ONE;
    assign mismatch   = (dut_resp != golden_sel);
    assign first_miss = mismatch && !res_det_q;

    always_comb begin
        golden_sel = '0;
        for (int i = 0; i < CYCLES; i++) begin
            if (k_q == 5'(i)) golden_sel = golden_q[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        k_d       = k_q;
        cur_fid_d = cur_fid_q;
        end_fid_d = end_fid_q;
        res_fid_d = res_fid_q;
        res_det_d = res_det_q;
        res_cyc_d = res_cyc_q;
        det_cnt_d = det_cnt_q;
        tot_cnt_d = tot_cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    det_cnt_d = '0;
                    tot_cnt_d = '0;
                    if (batch_end <= batch_start || batch_end == NO_FAULT) begin
                        state_d = DONE;
                    end else begin
                        state_d   = GOLDEN;
                        cur_fid_d = batch_start;
                        end_fid_d = batch_end;
                        lfsr_d    = SEED;
                        k_d       = '0;
                    end
                end
            end
            GOLDEN: begin
                lfsr_d = lfsr_step;
                k_d    = k_q + 5'd1;
                if (last_k) begin
                    state_d   = INJECT;
                    lfsr_d    = SEED;
                    k_d       = '0;
                    res_fid_d = cur_fid_q;
                    res_det_d = 1'b0;
                    res_cyc_d = '0;
                end
            end
            INJECT: begin
                lfsr_d = lfsr_step;
                k_d    = k_q + 5'd1;
                if (first_miss) begin
                    res_det_d = 1'b1;
                    res_cyc_d = k_q[3:0];
                end
`ifdef FI_EARLY_ABORT_EN
                if (last_k || first_miss) state_d = REPORT;
`else
                if (last_k) state_d = REPORT;
`endif
            end
            REPORT: begin
                if (res_ready) begin
                    tot_cnt_d = tot_cnt_q + FID_ONE;
                    det_cnt_d = det_cnt_q + {{(FID_W-1){1'b0}}, res_det_q};
                    cur_fid_d = next_fid;
                    if (next_fid == end_fid_q) begin
                        state_d = DONE;
                    end else begin
                        state_d   = INJECT;
                        lfsr_d    = SEED;
                        k_d       = '0;
                        res_fid_d = next_fid;
                        res_det_d = 1'b0;
                        res_cyc_d = '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lfsr_q    <= '0;
            k_q       <= '0;
            cur_fid_q <= '0;
            end_fid_q <= '0;
            res_fid_q <= '0;
            res_det_q <= 1'b0;
            res_cyc_q <= '0;
            det_cnt_q <= '0;
            tot_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            k_q       <= k_d;
            cur_fid_q <= cur_fid_d;
            end_fid_q <= end_fid_d;
            res_fid_q <= res_fid_d;
            res_det_q <= res_det_d;
            res_cyc_q <= res_cyc_d;
            det_cnt_q <= det_cnt_d;
            tot_cnt_q <= tot_cnt_d;
        end
    end

    // Golden responses are captured only during the single golden pass of a campaign
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CYCLES; i++) golden_q[i] <= '0;
        end else if (state_q == GOLDEN) begin
            for (int i = 0; i < CYCLES; i++) begin
                if (k_q == 5'(i)) golden_q[i] <= dut_resp;
            end
        end
    end

    assign stim_out     = lfsr_q;
    assign fault_id     = (state_q == INJECT) ? cur_fid_q : NO_FAULT;
    assign res_valid    = (state_q == REPORT);
    assign res_fid      = res_fid_q;
    assign res_detected = res_det_q;
    assign res_cycle    = res_cyc_q;
    assign busy         = (state_q == GOLDEN) || (state_q == INJECT) || (state_q == REPORT);
    assign done         = (state_q == DONE);
    assign det_cnt      = det_cnt_q;
    assign tot_cnt      = tot_cnt_q;

endmodule
